decode_stream: RTL and testbench

Bit-stream aligner directly upstream of the LZS decode controller. It pops 32-bit words from the compressed-input FIFO and presents a 13-bit MSB-first window of the next unconsumed bits. It then discards exactly `stream_width` bits on each `stream_ack`. It ends the stream on `in_last` drain or on `all_end` from the controller.

---
 rtl/decode_stream.sv | 122 ++++++++++++
 tb/tb_decode_stream.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stream.sv
// decode_stream
//   Bit-stream aligner in front of the LZS decode controller. Pops 32-bit
//   words from a first-word-fall-through FIFO into a 64-bit left-aligned
//   window and presents the next 13 unconsumed bits, MSB first. Each counted
//   stream_ack discards stream_width bits. A job ends when the in_last word
//   has been drained, or when the controller raises all_end.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   ce_decode      job enable; dropping it returns the block to IDLE
//   all_end        end marker from the controller; the window is discarded
//   in_data/in_valid/in_last  FIFO head word, not-empty flag, final-word flag
//   in_rd          FIFO pop; in_data is captured in the same cycle
//   stream_data    next 13 bits (bit 12 oldest), zero past the end of stream
//   stream_valid   stream_data is usable
//   stream_width   bits to consume on an ack (0..13)
//   stream_ack     consume request
//   under_err      sticky: over-consume or illegal width (cleared by rst only)
module decode_stream (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_decode,
  input  logic        all_end,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_rd,
  output logic [12:0] stream_data,
  output logic        stream_valid,
  input  logic [3:0]  stream_width,
  input  logic        stream_ack,
  output logic        under_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state, state_nx;
  logic [63:0] win_q, win_nx;   // left-aligned; win_q[63] is the next bit
  logic [6:0]  cnt_q, cnt_nx;   // valid bits in win_q, 0..64
  logic        last_q, last_nx;
  logic        err_nx;

  logic        active, ack_ok, bad_w, over;
  logic [6:0]  w, cnt_sh;
  logic [63:0] win_sh, word_al;

  assign stream_data = win_q[63:51];

  // Consume datapath. Bits of win_q below cnt_q are always zero, so a plain
  // left shift zero-fills and a refill word can simply be OR-ed in at the
  // post-shift fill point.
  always_comb begin
    active       = (state == S_RUN) || (state == S_DRAIN);
    stream_valid = active && ((cnt_q >= 7'd13) || (last_q && (cnt_q != 7'd0)));
    // Refill decision looks only at registered count, never at the ack.
    in_rd        = !rst && (state == S_RUN) && (cnt_q <= 7'd32) && in_valid;
    ack_ok       = stream_ack && stream_valid;
    bad_w        = stream_width > 4'd13;
    w            = (ack_ok && !bad_w) ? {3'd0, stream_width} : 7'd0;
    over         = w > cnt_q;
    cnt_sh       = over ? 7'd0 : (cnt_q - w);
    win_sh       = win_q << w;
    word_al      = {in_data, 32'd0} >> cnt_sh;
  end

  always_comb begin
    state_nx = state;
    win_nx   = win_q;
    cnt_nx   = cnt_q;
    last_nx  = last_q;
    err_nx   = under_err | (ack_ok & (bad_w | over));
    case (state)
      S_IDLE: begin
        win_nx  = 64'd0;
        cnt_nx  = 7'd0;
        last_nx = 1'b0;
        if (ce_decode) state_nx = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        win_nx = win_sh | (in_rd ? word_al : 64'd0);
        cnt_nx = cnt_sh + (in_rd ? 7'd32 : 7'd0);
        if (in_rd && in_last) begin
          last_nx  = 1'b1;
          state_nx = S_DRAIN;
        end
        if ((state == S_DRAIN) && ack_ok && !bad_w && (cnt_sh == 7'd0))
          state_nx = S_DONE;
        // Remaining FIFO words belong to the next job; only the window goes.
        if (all_end) begin
          state_nx = S_DONE;
          win_nx   = 64'd0;
          cnt_nx   = 7'd0;
        end
      end
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if ((state != S_IDLE) && !ce_decode) begin
      state_nx = S_IDLE;
      win_nx   = 64'd0;
      cnt_nx   = 7'd0;
      last_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      win_q     <= 64'd0;
      cnt_q     <= 7'd0;
      last_q    <= 1'b0;
      under_err <= 1'b0;
    end else begin
      state     <= state_nx;
      win_q     <= win_nx;
      cnt_q     <= cnt_nx;
      last_q    <= last_nx;
      under_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_decode_stream.sv
// Self-checking bench for decode_stream. The reference model keeps the
// unconsumed window as a queue of bits and the job phase as a small integer.
module tb_decode_stream;

  logic        clk = 1'b0;
  logic        rst, ce_decode, all_end, in_valid, in_last, in_rd;
  logic        stream_valid, stream_ack, under_err;
  logic [31:0] in_data;
  logic [12:0] stream_data;
  logic [3:0]  stream_width;

  always #5 clk = ~clk;

  decode_stream dut (
    .clk(clk), .rst(rst), .ce_decode(ce_decode), .all_end(all_end),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_rd(in_rd),
    .stream_data(stream_data), .stream_valid(stream_valid),
    .stream_width(stream_width), .stream_ack(stream_ack), .under_err(under_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bench FIFO: bit 32 is the in_last flag
  logic [32:0] fq[$];
  int          gap_pct = 0;
  bit          pop_flag = 0;

  task automatic refresh();
    in_valid = (fq.size() > 0) && ($urandom_range(99) >= gap_pct);
    in_data  = (fq.size() > 0) ? fq[0][31:0] : 32'h0;
    in_last  = (fq.size() > 0) ? fq[0][32] : 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_flag) void'(fq.pop_front());
    refresh();
  endtask

  // Reference model: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
  int m_phase = 0;
  bit wq[$];
  bit m_last = 0;
  bit m_err  = 0;
  bit chk_en = 0;
  bit cap_en = 0;
  bit cons[$];
  bit src[$];

  function automatic logic [12:0] m_data();
    logic [12:0] r;
    for (int i = 0; i < 13; i++) r[12-i] = (i < wq.size()) ? wq[i] : 1'b0;
    return r;
  endfunction

  function automatic logic m_valid();
    return ((m_phase == 1) || (m_phase == 2)) &&
           ((wq.size() >= 13) || (m_last && (wq.size() > 0)));
  endfunction

  function automatic logic m_rd();
    return !rst && (m_phase == 1) && (wq.size() <= 32) && in_valid;
  endfunction

  task automatic model_step();
    bit vld, rd, ack;
    int nph;
    vld = m_valid();
    rd  = m_rd();
    nph = m_phase;
    if (rst) begin
      m_phase = 0; wq.delete(); m_last = 0; m_err = 0;
      return;
    end
    ack = stream_ack && vld;
    if (ack) begin
      if (stream_width > 13) m_err = 1;
      else if (int'(stream_width) > wq.size()) begin m_err = 1; wq.delete(); end
      else for (int i = 0; i < int'(stream_width); i++) void'(wq.pop_front());
    end
    if (rd) begin
      for (int i = 31; i >= 0; i--) wq.push_back(in_data[i]);
      if (in_last) begin m_last = 1; nph = 2; end
    end
    if ((m_phase == 2) && ack && (stream_width <= 13) && (wq.size() == 0)) nph = 3;
    if (((m_phase == 1) || (m_phase == 2)) && all_end) begin nph = 3; wq.delete(); end
    if ((m_phase == 0) && ce_decode) nph = 1;
    if ((m_phase != 0) && !ce_decode) begin nph = 0; wq.delete(); m_last = 0; end
    m_phase = nph;
  endtask

  // Compare process: outputs vs model each cycle, then advance the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stream_valid", stream_valid, m_valid());
      chk("stream_data", stream_data, m_data());
      chk("in_rd", in_rd, m_rd());
      chk("under_err", under_err, m_err);
    end
    pop_flag = in_rd && in_valid;
    if (cap_en && stream_ack && stream_valid && (stream_width <= 13))
      for (int i = 0; i < int'(stream_width); i++) cons.push_back(stream_data[12-i]);
    model_step();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] wd;
    int cyc, wmax, bad;
    rst = 1; ce_decode = 0; all_end = 0; stream_ack = 0; stream_width = 0;
    refresh();
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    chk("rst_data", stream_data, 13'h0);
    chk("rst_valid", stream_valid, 1'b0);
    chk("rst_rd", in_rd, 1'b0);
    chk("rst_err", under_err, 1'b0);

    // Start-up and first consume
    tick();
    rst = 0;
    fq.push_back({1'b0, 32'h12345678});
    refresh();
    ce_decode = 1;
    @(negedge clk); chk("start_rd_idle", in_rd, 1'b0);
    tick();
    @(negedge clk); chk("start_rd", in_rd, 1'b1);
    tick();
    @(negedge clk);
    chk("start_rd_once", in_rd, 1'b0);
    chk("start_valid", stream_valid, 1'b1);
    chk("start_data", stream_data, 13'h0246);
    tick();
    fq.push_back({1'b0, 32'h9ABCDEF0});
    refresh();
    stream_ack = 1; stream_width = 9;
    @(negedge clk); chk("refill_with_ack", in_rd, 1'b1);
    tick();
    stream_ack = 0;
    @(negedge clk); chk("ack9_data", stream_data, 13'h0D15);

    // Single last word drained exactly
    ce_decode = 0;
    tick();
    fq.delete(); fq.push_back({1'b1, 32'hC0000000}); refresh();
    ce_decode = 1;
    tick(); tick();
    stream_ack = 1; stream_width = 9;
    @(negedge clk);
    chk("drain_data", stream_data, 13'h1800);
    chk("drain_valid", stream_valid, 1'b1);
    tick(); stream_width = 13;
    tick(); stream_width = 10;
    @(negedge clk); chk("drain_tail_valid", stream_valid, 1'b1);
    tick();
    stream_ack = 0;
    fq.push_back({1'b0, 32'hFFFFFFFF}); refresh();
    @(negedge clk);
    chk("done_valid", stream_valid, 1'b0);
    chk("done_no_rd", in_rd, 1'b0);
    chk("done_err", under_err, 1'b0);

    // Over-consume in DRAIN
    ce_decode = 0;
    tick();
    fq.delete(); fq.push_back({1'b1, 32'hA5A5A5A5}); refresh();
    ce_decode = 1;
    tick(); tick();
    stream_ack = 1; stream_width = 13;
    tick(); stream_width = 13;
    tick(); stream_width = 1;
    tick(); stream_width = 9;
    @(negedge clk); chk("over_pre_valid", stream_valid, 1'b1);
    tick();
    stream_ack = 0;
    @(negedge clk);
    chk("over_err", under_err, 1'b1);
    chk("over_done", stream_valid, 1'b0);
    tick(); ce_decode = 0; tick();
    @(negedge clk); chk("err_sticky", under_err, 1'b1);
    rst = 1; tick(); rst = 0;
    @(negedge clk); chk("err_cleared", under_err, 1'b0);

    // all_end with two words left in the FIFO
    fq.delete();
    fq.push_back({1'b0, 32'h11111111}); fq.push_back({1'b0, 32'h22222222});
    fq.push_back({1'b0, 32'h33333333}); fq.push_back({1'b0, 32'h44444444});
    refresh();
    ce_decode = 1;
    tick(); tick(); tick();
    stream_ack = 1; stream_width = 13;
    tick(); stream_width = 11;
    tick();
    stream_ack = 0; all_end = 1;
    @(negedge clk);
    chk("allend_rd", in_rd, 1'b0);
    chk("allend_valid", stream_valid, 1'b1);
    tick();
    all_end = 0;
    @(negedge clk);
    chk("allend_done", stream_valid, 1'b0);
    chk("allend_done_rd", in_rd, 1'b0);
    chk("fifo_residue", fq.size(), 2);
    tick(); tick();
    @(negedge clk); chk("fifo_residue_hold", fq.size(), 2);
    ce_decode = 0;
    tick();
    @(negedge clk); chk("idle_valid", stream_valid, 1'b0);
    fq.delete(); refresh();

    // Ignored ack in IDLE, then illegal width while valid
    stream_ack = 1; stream_width = 15;
    tick();
    @(negedge clk); chk("ack_idle_no_err", under_err, 1'b0);
    stream_ack = 0;
    fq.push_back({1'b0, 32'h0F0F0F0F}); refresh();
    ce_decode = 1;
    tick(); tick();
    stream_ack = 1; stream_width = 14;
    tick();
    stream_ack = 0;
    @(negedge clk);
    chk("illegal_w_err", under_err, 1'b1);
    chk("illegal_w_data", stream_data, 13'h01E1);
    rst = 1; ce_decode = 0;
    tick();
    rst = 0;
    fq.delete(); refresh();

    // Randomized job: widths 0..13, random FIFO gaps
    for (int i = 0; i < 2500; i++) begin
      wd = $urandom;
      fq.push_back({(i == 2499) ? 1'b1 : 1'b0, wd});
      for (int b = 31; b >= 0; b--) src.push_back(wd[b]);
    end
    gap_pct = 25;
    cons.delete();
    cap_en = 1;
    ce_decode = 1;
    refresh();
    cyc = 0;
    while ((cyc < 60000) && (m_phase != 3)) begin
      tick();
      stream_ack = ($urandom_range(9) != 0);
      wmax = 13;
      if (m_last && (wq.size() < 13)) wmax = wq.size();
      stream_width = 4'($urandom_range(wmax, 0));
      cyc++;
    end
    stream_ack = 0;
    cap_en = 0;
    chk("job_finished", (cyc < 60000), 1'b1);
    chk("consumed_len", cons.size(), src.size());
    bad = 0;
    for (int i = 0; i < cons.size() && i < src.size(); i++)
      if (cons[i] != src[i]) bad++;
    chk("consumed_bits", bad, 0);
    chk("random_err", under_err, 1'b0);
    ce_decode = 0;
    tick(); tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
